// File: rtl/i2c_subordinate_if.sv
// Host-side interface of the I2C subordinate.
// slave  : used by i2c_subordinate (drives receive data and status, takes read bytes).
// master : used by the local host / register file.
//   rx_data/rx_valid : byte written by the bus master, with a 1-cycle strobe
//   tx_req           : 1-cycle request for the next read byte
//   tx_data/tx_valid : read byte from the host, sampled at the load point
//   tx_underrun      : 1-cycle pulse, 0xFF was sent because tx_valid was low
//   busy/rw_mode     : addressed-transfer status and its R/W bit
//   done             : 1-cycle pulse on STOP ending an addressed transfer
interface i2c_subordinate_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_req;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_underrun;
    logic       busy;
    logic       rw_mode;
    logic       done;

    modport slave (
        output rx_data, rx_valid, tx_req, tx_underrun, busy, rw_mode, done,
        input  tx_data, tx_valid
    );

    modport master (
        input  rx_data, rx_valid, tx_req, tx_underrun, busy, rw_mode, done,
        output tx_data, tx_valid
    );
endinterface

// File: rtl/i2c_subordinate.sv
// I2C target at a fixed 7-bit address. SCL/SDA are oversampled on clk;
// START/STOP/repeated START are detected from synchronized edges. Write bytes
// are always ACKed, read bytes come from the host through the interface.
// No clock stretching, no general call, no 10-bit addressing.
// Ports:
//   clk, rst_n : system clock (>= 8x SCL), asynchronous active-low reset
//   SCL        : bus clock input
//   SDA        : open-drain data, driven low only when sda_oe is set
//   host       : host-side handshake (see i2c_subordinate_if)
module i2c_subordinate #(
    parameter logic [6:0] SUB_ADDR    = 7'h50,
    parameter int         SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  SCL,
    inout  wire                   SDA,
    i2c_subordinate_if.slave      host
);

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, RX_DATA, RX_ACK, TX_DATA, TX_ACK, WAIT_STOP
    } state_t;

    // ---------------- input synchronizers + edge detect ----------------
    // Reset to 1 (idle bus level) so leaving reset never produces a fake edge.
    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic                   scl_d, sda_d;
    logic                   scl_s, sda_s;
    logic                   scl_rise, scl_fall, sda_rise, sda_fall;
    logic                   start_det, stop_det;
    logic                   sda_in;

    assign sda_in = SDA;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], SCL};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
            scl_d    <= scl_sync[SYNC_STAGES-1];
            sda_d    <= sda_sync[SYNC_STAGES-1];
        end
    end

    assign scl_s     = scl_sync[SYNC_STAGES-1];
    assign sda_s     = sda_sync[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_d;
    assign scl_fall  = ~scl_s & scl_d;
    assign sda_rise  = sda_s & ~sda_d;
    assign sda_fall  = ~sda_s & sda_d;
    assign start_det = sda_fall & scl_s;
    assign stop_det  = sda_rise & scl_s;

    // ---------------- FSM state and datapath registers ----------------
    state_t     state, state_n;
    logic [2:0] cnt, cnt_n;
    logic [7:0] sh, sh_n;
    logic       byte_done, byte_done_n;   // 8th rise seen, act on next fall
    logic       sda_oe, sda_oe_n;
    logic [7:0] rx_data_n;
    logic       rx_valid_n, tx_req_n, underrun_n, busy_n, rw_n, done_n;

    assign SDA = sda_oe ? 1'b0 : 1'bz;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            cnt              <= '0;
            sh               <= '0;
            byte_done        <= 1'b0;
            sda_oe           <= 1'b0;
            host.rx_data     <= '0;
            host.rx_valid    <= 1'b0;
            host.tx_req      <= 1'b0;
            host.tx_underrun <= 1'b0;
            host.busy        <= 1'b0;
            host.rw_mode     <= 1'b0;
            host.done        <= 1'b0;
        end else begin
            state            <= state_n;
            cnt              <= cnt_n;
            sh               <= sh_n;
            byte_done        <= byte_done_n;
            sda_oe           <= sda_oe_n;
            host.rx_data     <= rx_data_n;
            host.rx_valid    <= rx_valid_n;
            host.tx_req      <= tx_req_n;
            host.tx_underrun <= underrun_n;
            host.busy        <= busy_n;
            host.rw_mode     <= rw_n;
            host.done        <= done_n;
        end
    end

    logic [7:0] sh_in;      // shift register with the sampled bit appended
    logic [7:0] load_sh;    // byte to transmit at a load point
    logic       load_oe;
    assign sh_in   = {sh[6:0], sda_s};
    assign load_sh = host.tx_valid ? host.tx_data : 8'hFF;
    assign load_oe = host.tx_valid ? ~host.tx_data[7] : 1'b0;

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        sh_n        = sh;
        byte_done_n = byte_done;
        sda_oe_n    = sda_oe;
        rx_data_n   = host.rx_data;
        busy_n      = host.busy;
        rw_n        = host.rw_mode;
        rx_valid_n  = 1'b0;
        tx_req_n    = 1'b0;
        underrun_n  = 1'b0;
        done_n      = 1'b0;

        if (start_det) begin
            // busy survives a repeated START; only a mismatch or STOP clears it
            state_n     = ADDR;
            cnt_n       = '0;
            sda_oe_n    = 1'b0;
            byte_done_n = 1'b0;
        end else if (stop_det) begin
            state_n     = IDLE;
            cnt_n       = '0;
            sda_oe_n    = 1'b0;
            byte_done_n = 1'b0;
            done_n      = host.busy;
            busy_n      = 1'b0;
        end else begin
            unique case (state)
                ADDR: begin
                    if (scl_rise) begin
                        sh_n  = sh_in;
                        cnt_n = cnt + 3'd1;
                        if (cnt == 3'd7) begin
                            if (sh_in[7:1] == SUB_ADDR) begin
                                rw_n        = sh_in[0];
                                busy_n      = 1'b1;
                                tx_req_n    = sh_in[0];
                                byte_done_n = 1'b1;
                            end else begin
                                state_n = WAIT_STOP;
                                busy_n  = 1'b0;
                            end
                        end
                    end else if (scl_fall && byte_done) begin
                        state_n     = ADDR_ACK;
                        sda_oe_n    = 1'b1;
                        byte_done_n = 1'b0;
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        cnt_n = '0;
                        if (host.rw_mode) begin
                            state_n    = TX_DATA;
                            sh_n       = load_sh;
                            sda_oe_n   = load_oe;
                            underrun_n = ~host.tx_valid;
                        end else begin
                            state_n  = RX_DATA;
                            sda_oe_n = 1'b0;
                        end
                    end
                end
                RX_DATA: begin
                    if (scl_rise) begin
                        sh_n  = sh_in;
                        cnt_n = cnt + 3'd1;
                        if (cnt == 3'd7) begin
                            rx_data_n   = sh_in;
                            rx_valid_n  = 1'b1;
                            byte_done_n = 1'b1;
                        end
                    end else if (scl_fall && byte_done) begin
                        state_n     = RX_ACK;
                        sda_oe_n    = 1'b1;
                        byte_done_n = 1'b0;
                    end
                end
                RX_ACK: begin
                    if (scl_fall) begin
                        state_n  = RX_DATA;
                        sda_oe_n = 1'b0;
                        cnt_n    = '0;
                    end
                end
                TX_DATA: begin
                    // sh[7] is the bit currently on the bus
                    if (scl_rise) begin
                        cnt_n = cnt + 3'd1;
                        if (cnt == 3'd7) byte_done_n = 1'b1;
                    end else if (scl_fall) begin
                        if (byte_done) begin
                            state_n     = TX_ACK;
                            sda_oe_n    = 1'b0;
                            byte_done_n = 1'b0;
                        end else begin
                            sh_n     = {sh[6:0], 1'b1};
                            sda_oe_n = ~sh[6];
                        end
                    end
                end
                TX_ACK: begin
                    if (scl_rise) begin
                        if (!sda_s) begin
                            tx_req_n    = 1'b1;
                            byte_done_n = 1'b1;
                        end else begin
                            state_n = WAIT_STOP;
                        end
                    end else if (scl_fall && byte_done) begin
                        state_n     = TX_DATA;
                        byte_done_n = 1'b0;
                        cnt_n       = '0;
                        sh_n        = load_sh;
                        sda_oe_n    = load_oe;
                        underrun_n  = ~host.tx_valid;
                    end
                end
                default: ;  // IDLE / WAIT_STOP: only START or STOP leave
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_subordinate.sv
// Bench for i2c_subordinate: a bus-master model drives SCL/SDA, a host model
// answers tx_req from a queue, and a scoreboard monitor compares every host
// strobe (rx_valid, tx_req, tx_underrun, done) with expected events.
module tb_i2c_subordinate;
    localparam time Q = 80;   // quarter SCL period (8 clk)

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic scl = 1'b1;
    logic m_low = 1'b0;
    wire  SDA;

    pullup (SDA);
    assign SDA = m_low ? 1'b0 : 1'bz;

    i2c_subordinate_if hif ();

    i2c_subordinate #(.SUB_ADDR(7'h50), .SYNC_STAGES(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .SCL   (scl),
        .SDA   (SDA),
        .host  (hif)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef enum logic [1:0] {EV_RX, EV_TXREQ, EV_UNDER, EV_DONE} ev_kind_t;
    typedef struct { ev_kind_t kind; logic [7:0] data; } ev_t;
    typedef struct { logic valid; logic [7:0] data; } host_t;

    ev_t   exp_q[$];
    host_t host_q[$];
    host_t host_cur;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_ev(input ev_kind_t k, input logic [7:0] d);
        ev_t e;
        e.kind = k;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic sb_pop(input ev_kind_t k, input logic [7:0] d);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected: got event %0d data %0h expected none", k, d);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || (k == EV_RX && e.data !== d)) begin
                errors++;
                $display("FAIL sb_event: got event %0d data %0h expected event %0d data %0h",
                         k, d, e.kind, e.data);
            end
        end
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (rst_n) begin
            if (hif.rx_valid)    sb_pop(EV_RX, hif.rx_data);
            if (hif.tx_req)      sb_pop(EV_TXREQ, 8'h00);
            if (hif.tx_underrun) sb_pop(EV_UNDER, 8'h00);
            if (hif.done)        sb_pop(EV_DONE, 8'h00);
        end
    end

    // host model: answers each tx_req with the next queued byte
    always @(negedge clk) begin
        if (rst_n && hif.tx_req) begin
            if (host_q.size() > 0) begin
                host_cur = host_q.pop_front();
                hif.tx_valid = host_cur.valid;
                hif.tx_data  = host_cur.data;
            end else begin
                hif.tx_valid = 1'b0;
            end
        end
    end

    // flags any low on SDA that the master did not cause
    logic watch = 1'b0;
    int   drive_viol = 0;
    always @(negedge clk) begin
        if (watch && !m_low && SDA === 1'b0) drive_viol++;
    end

    // ---------------- bus master model ----------------
    task automatic clk_bit(input logic drive_low, output logic sampled);
        m_low = drive_low;
        #Q scl = 1'b1;
        #Q sampled = (SDA !== 1'b0);
        #Q scl = 1'b0;
        #Q;
    endtask

    task automatic bus_start();
        m_low = 1'b1;
        #Q scl = 1'b0;
        #Q;
    endtask

    task automatic bus_rstart();
        m_low = 1'b0;
        #Q scl = 1'b1;
        #Q;
        bus_start();
    endtask

    task automatic bus_stop();
        m_low = 1'b1;
        #Q scl = 1'b1;
        #Q m_low = 1'b0;
        #Q;
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) clk_bit(!b[i], s);
        clk_bit(1'b0, s);
        ack = s;   // 0 = ACK
    endtask

    task automatic read_byte(output logic [7:0] b, input logic master_ack);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            clk_bit(1'b0, s);
            b[i] = s;
        end
        clk_bit(master_ack, s);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not end within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        logic       ack;
        logic [7:0] rb;
        logic       s;

        hif.tx_valid = 1'b0;
        hif.tx_data  = 8'h00;

        // reset state
        #23;
        check("rst_rx_data", hif.rx_data, 8'h00);
        check("rst_busy", hif.busy, 1'b0);
        check("rst_rw_mode", hif.rw_mode, 1'b0);
        check("rst_done", hif.done, 1'b0);
        check("rst_sda_released", SDA !== 1'b0, 1'b1);
        rst_n = 1'b1;
        #(4*Q);

        // write: A0, 12, 5A
        expect_ev(EV_RX, 8'h12);
        expect_ev(EV_RX, 8'h5A);
        expect_ev(EV_DONE, 8'h00);
        bus_start();
        write_byte(8'hA0, ack); check("wr_addr_ack", ack, 1'b0);
        check("wr_busy", hif.busy, 1'b1);
        check("wr_rw_mode", hif.rw_mode, 1'b0);
        write_byte(8'h12, ack); check("wr_d0_ack", ack, 1'b0);
        write_byte(8'h5A, ack); check("wr_d1_ack", ack, 1'b0);
        bus_stop();
        #Q;
        check("wr_busy_end", hif.busy, 1'b0);

        // address mismatch: A2, 33
        watch = 1'b1;
        bus_start();
        write_byte(8'hA2, ack); check("mm_addr_nack", ack, 1'b1);
        check("mm_busy", hif.busy, 1'b0);
        write_byte(8'h33, ack); check("mm_d0_nack", ack, 1'b1);
        bus_stop();
        #Q;
        watch = 1'b0;
        check("mm_no_drive", drive_viol, 0);
        check("mm_busy_end", hif.busy, 1'b0);

        // read: 3C (ACK), C3 (NACK)
        host_q.push_back('{1'b1, 8'h3C});
        host_q.push_back('{1'b1, 8'hC3});
        expect_ev(EV_TXREQ, 8'h00);
        expect_ev(EV_TXREQ, 8'h00);
        expect_ev(EV_DONE, 8'h00);
        bus_start();
        write_byte(8'hA1, ack); check("rd_addr_ack", ack, 1'b0);
        check("rd_rw_mode", hif.rw_mode, 1'b1);
        read_byte(rb, 1'b1); check("rd_byte0", rb, 8'h3C);
        read_byte(rb, 1'b0); check("rd_byte1", rb, 8'hC3);
        bus_stop();
        #Q;
        check("rd_busy_end", hif.busy, 1'b0);

        // underrun: host has no data -> 0xFF
        host_q.push_back('{1'b0, 8'h00});
        expect_ev(EV_TXREQ, 8'h00);
        expect_ev(EV_UNDER, 8'h00);
        expect_ev(EV_DONE, 8'h00);
        bus_start();
        write_byte(8'hA1, ack); check("ur_addr_ack", ack, 1'b0);
        read_byte(rb, 1'b0); check("ur_byte", rb, 8'hFF);
        bus_stop();
        #Q;

        // repeated START: write 07, Sr, read 96
        host_q.push_back('{1'b1, 8'h96});
        expect_ev(EV_RX, 8'h07);
        expect_ev(EV_TXREQ, 8'h00);
        expect_ev(EV_DONE, 8'h00);
        bus_start();
        write_byte(8'hA0, ack); check("sr_wr_ack", ack, 1'b0);
        write_byte(8'h07, ack); check("sr_d0_ack", ack, 1'b0);
        check("sr_rw_before", hif.rw_mode, 1'b0);
        bus_rstart();
        check("sr_busy_held", hif.busy, 1'b1);
        write_byte(8'hA1, ack); check("sr_rd_ack", ack, 1'b0);
        check("sr_rw_after", hif.rw_mode, 1'b1);
        read_byte(rb, 1'b0); check("sr_byte", rb, 8'h96);
        bus_stop();
        #Q;

        // reset while ACKing a write byte
        expect_ev(EV_RX, 8'h44);
        bus_start();
        write_byte(8'hA0, ack); check("ra_addr_ack", ack, 1'b0);
        for (int i = 7; i >= 0; i--) clk_bit(!(8'h44 >> i & 8'h01), s);
        m_low = 1'b0;
        #(2*Q);
        check("ra_sda_driven", SDA === 1'b0, 1'b1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("ra_sda_released_async", SDA !== 1'b0, 1'b1);
        check("ra_busy", hif.busy, 1'b0);
        check("ra_rx_data", hif.rx_data, 8'h00);
        #50 rst_n = 1'b1;
        #Q scl = 1'b1;
        #(2*Q);
        check("ra_idle", SDA !== 1'b0, 1'b1);
        expect_ev(EV_RX, 8'h99);
        expect_ev(EV_DONE, 8'h00);
        bus_start();
        write_byte(8'hA0, ack); check("ra_wr_ack", ack, 1'b0);
        write_byte(8'h99, ack); check("ra_d0_ack", ack, 1'b0);
        bus_stop();
        #(4*Q);

        check("sb_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/i2c_subordinate.md
Name: i2c_subordinate

Overview:
- I2C target (subordinate) for the I2C_master bus, at a fixed 7-bit address.
- Oversamples SCL/SDA on the system clock and detects START, repeated START and STOP.
- Receives write bytes and ACKs them; transmits read bytes supplied by a local register-file/host.
- No clock stretching, no general call, no 10-bit addressing.

Parameters:
- SUB_ADDR, 7'h50: 7-bit bus address this block responds to.
- SYNC_STAGES, 2: flops in each SCL/SDA input synchronizer (≥2).

Ports:
- clk  input  1  system clock; must be ≥8× SCL frequency (e.g. 50 MHz for 400 kHz).
- rst_n  input  1  asynchronous active-low reset.
- SCL  input  1  bus clock from master (pad input).
- SDA  inout  1  open-drain data; driven '0' when sda_oe=1, else 'z'.
- rx_data  output  8  last byte written by master.
- rx_valid  output  1  1-cycle pulse: rx_data updated.
- tx_req  output  1  1-cycle pulse: next read byte needed.
- tx_data  input  8  read byte from host.
- tx_valid  input  1  tx_data valid; sampled at load point.
- tx_underrun  output  1  1-cycle pulse: tx_valid low at load, 0xFF sent.
- busy  output  1  high from address match until STOP or non-matching repeated START.
- rw_mode  output  1  R/W bit of current addressed transfer (1=read).
- done  output  1  1-cycle pulse on STOP ending an addressed transfer.

Behaviour:
- Reset (async): state IDLE, sda_oe=0 (SDA released immediately), rx_data=0, every pulse output 0, busy=0, rw_mode=0, bit counter 0.
- Inputs pass through SYNC_STAGES flops + one history flop. scl_rise/scl_fall/sda_rise/sda_fall are 1-cycle pulses. Detection latency SYNC_STAGES+1 clk cycles.
- START = sda_fall while synced SCL=1. STOP = sda_rise while SCL=1.
- START/STOP take priority over every state and every SCL edge in the same cycle.
- START (incl. repeated) → ADDR, counter=0, SDA released.
- STOP → IDLE, SDA released; done pulses if busy was 1; busy=0.
- Data sampled on scl_rise, SDA changed only on scl_fall. 3-bit counter counts SCL rises, wraps 7→0.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits MSB-first. At 8th scl_rise compare byte[7:1] to SUB_ADDR.
    - Match: latch rw_mode=byte[0], busy=1; tx_req pulses if read. At next scl_fall → ADDR_ACK, sda_oe=1.
    - Mismatch: → WAIT_STOP; SDA never driven; busy=0.
  - ADDR_ACK: hold SDA low through 9th SCL high.
    - Read → TX_DATA; write → RX_DATA. The 9th scl_fall performs the ADDR_ACK→next-state transition.
    - RX_DATA: sda_oe=0 at that edge.
    - TX_DATA: at that edge the tx byte is loaded and bit 7 is driven immediately.
  - RX_DATA: shift 8 bits. At 8th scl_rise rx_data<=byte, rx_valid pulse. Next scl_fall → RX_ACK, sda_oe=1 (always ACK).
  - RX_ACK: release at 9th scl_fall → RX_DATA.
  - TX_DATA: load shift reg with tx_data if tx_valid, else 8'hFF and tx_underrun pulse. On each scl_fall drive sda_oe = ~bit (MSB first). After the 8th bit's scl_fall → TX_ACK, sda_oe=0.
  - TX_ACK: sample SDA at 9th scl_rise.
    - 0 (master ACK): tx_req pulse; at 9th scl_fall → TX_DATA, load next byte.
    - 1 (NACK): → WAIT_STOP, SDA stays released.
  - WAIT_STOP: ignore SCL; only START/STOP exit.
- Host contract: tx_data/tx_valid must be stable by the scl_fall following tx_req (≥ half SCL period). No rx backpressure; the host must consume rx_data within one byte time.
- SDA is never driven while SCL is high except ACK/data bits already set before the rise.

Test Plan:
- Write: START, 0xA0 (0x50,W), 0x12, 0x5A, STOP → SDA low on 9th clock of each byte; rx_valid ×2 with 0x12 then 0x5A; busy 1→0; done once; rw_mode=0.
- Address mismatch: START, 0xA2, 0x33, STOP → sda_oe never 1; no rx_valid/tx_req; busy=0; no done.
- Read: START, 0xA1; host answers each tx_req with 0x3C then 0xC3; master ACKs byte 1, NACKs byte 2; STOP → SDA shows 0011_1100 then 1100_0011; tx_req ×2 (addr rise 8, TX_ACK rise 9); WAIT_STOP then done.
- Underrun: read with tx_valid=0 at load → bus byte 0xFF, tx_underrun one pulse, transfer continues normally.
- Repeated START: write 0xA0, 0x07, then Sr, 0xA1, read one byte with NACK, STOP → rx_valid(0x07); busy stays 1 across Sr; rw_mode 0→1; single done at STOP.
- Reset mid-ACK: assert rst_n=0 while sda_oe=1 in RX_ACK → SDA 'z' without waiting for clk; after release, block idle until a new START; next write works.
